// File: rtl/sipo_pkg.sv
// Shared types and defaults for the serial-to-parallel receiver.
package sipo_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RECV = 1'b1
   } state_t;

   localparam int unsigned DEF_DATA_W = 4;
   localparam int unsigned DEF_CNT_W  = 8;

   // Bit-counter width: enough to index DATA_W bits, never below one bit.
   function automatic int unsigned bcnt_width(input int unsigned data_w);
      int unsigned w;
      w = $clog2(data_w);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/sipo_rx.sv
// Reassembles an LSB-first serial stream into words on a valid/ready port,
// with a single output buffer plus overrun and framing-error pulses.
module sipo_rx
   import sipo_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned CNT_W  = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              bit_valid,
   input  logic              inbit,
   output logic [DATA_W-1:0] word_data,
   output logic              word_valid,
   input  logic              word_ready,
   output logic              overrun,
   output logic              frame_err,
   output logic [CNT_W-1:0]  word_cnt
);

   localparam int unsigned BCNT_W = bcnt_width(DATA_W);
   localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(DATA_W - 1);

   state_t              state,      state_n;
   logic [BCNT_W-1:0]   bit_cnt,    bit_cnt_n;
   logic [DATA_W-1:0]   shift_reg,  shift_n;
   logic [DATA_W-1:0]   word_data_n;
   logic                word_valid_n;
   logic                overrun_n;
   logic                frame_err_n;
   logic [CNT_W-1:0]    word_cnt_n;

   // Next-state, datapath and output-buffer decisions.
   always_comb begin
      state_n      = state;
      bit_cnt_n    = bit_cnt;
      shift_n      = shift_reg;
      word_data_n  = word_data;
      word_valid_n = word_valid;
      word_cnt_n   = word_cnt;
      overrun_n    = 1'b0;
      frame_err_n  = 1'b0;

      // A pure consume empties the buffer; a completion below may refill it.
      if (word_valid && word_ready) begin
         word_valid_n = 1'b0;
      end

      unique case (state)
         IDLE: begin
            if (start) begin
               state_n   = RECV;
               bit_cnt_n = '0;
               shift_n   = '0;
            end
         end
         RECV: begin
            if (start) begin
               // Restart; only an abandoned partial word is an error.
               frame_err_n = (bit_cnt != '0);
               bit_cnt_n   = '0;
               shift_n     = '0;
            end else if (bit_valid) begin
               shift_n = {inbit, shift_reg[DATA_W-1:1]};
               if (bit_cnt == LAST_BIT) begin
                  state_n   = IDLE;
                  bit_cnt_n = '0;
                  if (!word_valid || word_ready) begin
                     word_data_n  = shift_n;
                     word_valid_n = 1'b1;
                     word_cnt_n   = word_cnt + CNT_W'(1);
                  end else begin
                     overrun_n = 1'b1;
                  end
               end else begin
                  bit_cnt_n = bit_cnt + BCNT_W'(1);
               end
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // State and output registers, synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         shift_reg  <= '0;
         word_data  <= '0;
         word_valid <= 1'b0;
         overrun    <= 1'b0;
         frame_err  <= 1'b0;
         word_cnt   <= '0;
      end else begin
         state      <= state_n;
         bit_cnt    <= bit_cnt_n;
         shift_reg  <= shift_n;
         word_data  <= word_data_n;
         word_valid <= word_valid_n;
         overrun    <= overrun_n;
         frame_err  <= frame_err_n;
         word_cnt   <= word_cnt_n;
      end
   end

endmodule

// File: doc/sipo_rx.md
# sipo_rx

Serial-to-parallel receiver: the stage directly downstream of the team's 4-bit PISO shifter. It reassembles the PISO's LSB-first serial bitstream into parallel words. Each word is presented on a valid/ready output port. The block provides one word of output buffering and flags overrun and framing errors.

## Interface
Parameters:
- DATA_W, 4, word width in bits (≥2)
- CNT_W, 8, width of the received-word counter

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  frame start; marks the cycle upstream loads a new word
- bit_valid  in  1  inbit is a valid data bit this cycle
- inbit  in  1  serial data, LSB first
- word_data  out  DATA_W  assembled word
- word_valid  out  1  word_data holds an unconsumed word
- word_ready  in  1  consumer accepts word_data when word_valid & word_ready
- overrun  out  1  one-cycle pulse: completed word dropped because the output buffer was full
- frame_err  out  1  one-cycle pulse: start arrived while a word was partially received
- word_cnt  out  CNT_W  count of words delivered to the output buffer, wraps modulo 2^CNT_W

## Operation
- FSM states: IDLE and RECV.
- IDLE:
  - start → RECV; bit counter and shift register cleared.
  - bit_valid without a prior start is ignored.
- RECV:
  - Each cycle with bit_valid=1 and start=0: shift_reg ← {inbit, shift_reg[DATA_W-1:1]}; bit_cnt increments.
  - Final bit (bit_cnt == DATA_W-1 with bit_valid) completes the word; FSM → IDLE.
- Completion:
  - Output buffer is free if word_valid=0, or if word_valid & word_ready in the same cycle. If free: word_data ← completed word, word_valid ← 1, word_cnt increments.
  - Otherwise: the word is dropped, overrun pulses, and word_data/word_valid/word_cnt are unchanged.
- start while in RECV with bit_cnt > 0: frame_err pulses, partial word discarded, restart (stay RECV, bit_cnt=0).
- start while in RECV with bit_cnt == 0: silent restart, no error.
- start and bit_valid in the same cycle: start wins and that bit is ignored.
- Gaps (bit_valid=0) in RECV hold all state indefinitely.
- Consume (word_valid & word_ready with no completion that cycle): word_valid ← 0; word_data retains its last value.
- word_data must stay stable while word_valid=1 and word_ready=0.
- word_cnt wraps from 2^CNT_W-1 to 0 with no flag.

## Timing
- Reset values: word_data=0, word_valid=0, overrun=0, frame_err=0, word_cnt=0. FSM=IDLE, bit_cnt=0, shift_reg=0.
- rst overrides all inputs, including mid-word and with word_valid=1; the buffered word is lost.
- Latency: word_valid rises the cycle after the final bit is sampled. A word spans ≥DATA_W+1 cycles from start.
- overrun and frame_err are registered and high for exactly one cycle, the cycle after the triggering edge.
- word_ready is a combinational input only; no output depends combinationally on any input.
- Back-to-back words with no bubble: start in the cycle after the final bit. At full rate the sustained throughput is one word per DATA_W+1 cycles.

## Structure
- Package sipo_pkg:
  - state enum (IDLE, RECV)
  - default DATA_W and CNT_W constants
  - bit-counter width function clog2(DATA_W)
- Single module, no sub-modules.

## Test plan
- Basic word: rst, start, then bit_valid with inbit 1,0,1,1; word_ready=1 → word_data=4'b1101, word_valid high for 1 cycle, word_cnt=1.
- Backpressure: word_ready=0; receive 4'hA, then 4'h5 → word_data stays 4'hA, overrun pulses once, word_cnt=1. Then raise word_ready → 4'hA is consumed and word_valid falls.
- Simultaneous consume and complete: word_valid=1 with 4'h3; final bit of 4'hC lands in the same cycle that word_ready=1 → word_data=4'hC, word_valid stays 1, no overrun, word_cnt increments.
- Framing: start, two bits, start, then four bits 0,1,1,0 → frame_err pulses once and word_data=4'h6. Start+bit_valid in the same cycle → that bit is ignored.
- Reset mid-operation: rst asserted after 2 bits with word_valid=1 → all outputs 0 the next cycle. Also drive bit_valid without start after reset → no word produced.
- Gaps and wrap: random bit_valid gaps across 256 words with word_ready=1 → every word matches, and word_cnt returns to 0.
